// File: rtl/gf180mcu_fd_sc_mcu7t5v0__mbit_pkg.sv
// Shared limits and helpers for the multi-bit synchroniser cell family.
package gf180mcu_fd_sc_mcu7t5v0__mbit_pkg;

  localparam int unsigned WidthMin        = 1;
  localparam int unsigned WidthMax        = 32;
  localparam int unsigned DepthMin        = 2;
  localparam int unsigned DepthMax        = 4;
  localparam int unsigned StableCyclesMin = 1;
  localparam int unsigned StableCyclesMax = 255;

  // Scan chain position of stage[stage][bit]; SI feeds index 0, SO is the top index.
  function automatic int unsigned chain_idx(input int unsigned stage, input int unsigned bit_pos,
                                            input int unsigned width);
    return stage * width + bit_pos;
  endfunction

  function automatic int unsigned cnt_width(input int unsigned stable_cycles);
    return $clog2(stable_cycles + 1);
  endfunction

endpackage

// File: rtl/gf180mcu_fd_sc_mcu7t5v0__syncq_mbit_func.sv
// Untimed functional model: synchroniser stages on a flat scan chain plus the STABLE counter.
module gf180mcu_fd_sc_mcu7t5v0__syncq_mbit_func
  import gf180mcu_fd_sc_mcu7t5v0__mbit_pkg::*;
#(
  parameter int unsigned Width        = 4,
  parameter int unsigned Depth        = 2,
  parameter int unsigned StableCycles = 3
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [Width-1:0] d_i,
  input  logic             e_i,
  input  logic             se_i,
  input  logic             si_i,
  output logic [Width-1:0] q_o,
  output logic             so_o,
  output logic             stable_o
);

  localparam int unsigned ChainLen = Width * Depth;
  localparam int unsigned CntW     = cnt_width(StableCycles);
  localparam int unsigned LastIdx  = chain_idx(Depth - 1, 0, Width);
  localparam logic [CntW-1:0] CntMax = CntW'(StableCycles);

  if (Width < WidthMin || Width > WidthMax || Depth < DepthMin || Depth > DepthMax ||
      StableCycles < StableCyclesMin || StableCycles > StableCyclesMax) begin : gen_bad_param
    $error("syncq_mbit: parameter out of legal range");
  end

  logic [ChainLen-1:0] chain_q, chain_d;
  logic [CntW-1:0]     cnt_q, cnt_d;
  logic [Width-1:0]    q_next;

  // Functional shift moves a whole stage per edge; scan shifts one bit per edge.
  always_comb begin
    chain_d = chain_q;
    if (se_i) begin
      chain_d = {chain_q[ChainLen-2:0], si_i};
    end else if (e_i) begin
      chain_d = {chain_q[ChainLen-Width-1:0], d_i};
    end
  end

  assign q_next = chain_d[LastIdx +: Width];

  always_comb begin
    cnt_d = cnt_q;
    if (se_i || (q_next != chain_q[LastIdx +: Width])) begin
      cnt_d = '0;
    end else if (cnt_q != CntMax) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      chain_q <= '0;
      cnt_q   <= '0;
    end else begin
      chain_q <= chain_d;
      cnt_q   <= cnt_d;
    end
  end

  assign q_o      = chain_q[LastIdx +: Width];
  assign so_o     = chain_q[ChainLen-1];
  assign stable_o = (cnt_q == CntMax);

endmodule

// File: rtl/gf180mcu_fd_sc_mcu7t5v0__syncq_mbit.sv
// Multi-bit multi-stage synchroniser cell with scan, hold enable and STABLE flag.
module gf180mcu_fd_sc_mcu7t5v0__syncq_mbit
  import gf180mcu_fd_sc_mcu7t5v0__mbit_pkg::*;
#(
  parameter int unsigned WIDTH         = 4,
  parameter int unsigned DEPTH         = 2,
  parameter int unsigned STABLE_CYCLES = 3
) (
`ifdef USE_POWER_PINS
  inout  wire              VDD,
  inout  wire              VSS,
`endif
  input  logic             CLK,
  input  logic             RST,
  input  logic [WIDTH-1:0] D,
  input  logic             E,
  input  logic             SE,
  input  logic             SI,
  output logic [WIDTH-1:0] Q,
  output logic             SO,
  output logic             STABLE
);

  gf180mcu_fd_sc_mcu7t5v0__syncq_mbit_func #(
    .Width       (WIDTH),
    .Depth       (DEPTH),
    .StableCycles(STABLE_CYCLES)
  ) u_func (
    .clk_i   (CLK),
    .rst_i   (RST),
    .d_i     (D),
    .e_i     (E),
    .se_i    (SE),
    .si_i    (SI),
    .q_o     (Q),
    .so_o    (SO),
    .stable_o(STABLE)
  );

`ifndef FUNCTIONAL
  specify
    (CLK *> Q)      = (1, 1);
    (CLK => SO)     = (1, 1);
    (CLK => STABLE) = (1, 1);
    (RST *> Q)      = (1, 1);
    (RST => SO)     = (1, 1);
    (RST => STABLE) = (1, 1);
    $setuphold(posedge CLK, D, 1, 1);
    $setuphold(posedge CLK, E, 1, 1);
    $setuphold(posedge CLK, SE, 1, 1);
    $setuphold(posedge CLK, SI, 1, 1);
    $recrem(negedge RST, posedge CLK, 1, 1);
  endspecify
`endif

endmodule

// File: tb/tb_gf180mcu_fd_sc_mcu7t5v0__syncq_mbit.sv
// Directed bench: default cell (4x2, STABLE after 3) and corner cell (1x4, STABLE after 1).
module tb_gf180mcu_fd_sc_mcu7t5v0__syncq_mbit;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] d;
  logic       e, se, si;
  logic [3:0] q;
  logic       so, stable;
  logic       d2, e2, se2, si2;
  logic       q2, so2, stable2;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  gf180mcu_fd_sc_mcu7t5v0__syncq_mbit #(
    .WIDTH(4), .DEPTH(2), .STABLE_CYCLES(3)
  ) dut (
    .CLK(clk), .RST(rst), .D(d), .E(e), .SE(se), .SI(si), .Q(q), .SO(so), .STABLE(stable)
  );

  gf180mcu_fd_sc_mcu7t5v0__syncq_mbit #(
    .WIDTH(1), .DEPTH(4), .STABLE_CYCLES(1)
  ) dut2 (
    .CLK(clk), .RST(rst), .D(d2), .E(e2), .SE(se2), .SI(si2), .Q(q2), .SO(so2),
    .STABLE(stable2)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  logic [7:0] scan_pat;

  initial begin
    rst = 1'b1; d = 4'h0; e = 1'b1; se = 1'b0; si = 1'b0;
    d2 = 1'b0; e2 = 1'b1; se2 = 1'b0; si2 = 1'b0;
    scan_pat = 8'b0100_1101; // bit0 shifted first: 1,0,1,1,0,0,1,0

    // 1. reset and idle
    #1;
    check("rst_q", 32'(q), 32'h0);
    check("rst_so", 32'(so), 32'h0);
    check("rst_stable", 32'(stable), 32'h0);
    @(negedge clk);
    rst = 1'b0;
    tick(); tick();
    check("idle_stable_e2", 32'(stable), 32'h0);
    tick();
    check("idle_stable_e3", 32'(stable), 32'h1);
    tick();
    check("idle_stable_e4", 32'(stable), 32'h1);

    // 2. latency and STABLE drop
    d = 4'hA;
    tick();
    check("lat_q_e1", 32'(q), 32'h0);
    tick();
    check("lat_q_e2", 32'(q), 32'hA);
    check("lat_stable_e2", 32'(stable), 32'h0);
    tick(); tick();
    check("lat_stable_e4", 32'(stable), 32'h0);
    tick();
    check("lat_stable_e5", 32'(stable), 32'h1);

    // 3. hold
    e = 1'b0;
    for (int i = 0; i < 6; i++) begin
      d = (i % 2 == 0) ? 4'h5 : 4'h3;
      tick();
    end
    check("hold_q", 32'(q), 32'hA);
    check("hold_stable", 32'(stable), 32'h1);

    // 4. scan shift in then out
    se = 1'b1; e = 1'b1;
    for (int i = 0; i < 8; i++) begin
      si = scan_pat[i];
      tick();
    end
    check("scan_q", 32'(q), 32'hB);
    check("scan_so", 32'(so), 32'h1);
    check("scan_stable", 32'(stable), 32'h0);
    si = 1'b0;
    for (int i = 0; i < 8; i++) begin
      check($sformatf("scan_out_%0d", i), 32'(so), 32'(scan_pat[i]));
      tick();
    end
    check("scan_flushed_q", 32'(q), 32'h0);

    // 5. async reset mid-scan
    se = 1'b0; d = 4'hF;
    tick(); tick();
    check("pre5_q", 32'(q), 32'hF);
    se = 1'b1; si = 1'b1;
    for (int i = 0; i < 4; i++) tick();
    check("mid_scan_q", 32'(q), 32'hF);
    check("mid_scan_so", 32'(so), 32'h1);
    #1 rst = 1'b1;
    #1;
    check("async_q", 32'(q), 32'h0);
    check("async_so", 32'(so), 32'h0);
    check("async_stable", 32'(stable), 32'h0);
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 4; i++) tick();
    check("rescan_q_e4", 32'(q), 32'h0);
    check("rescan_so_e4", 32'(so), 32'h0);
    si = 1'b0;
    for (int i = 0; i < 4; i++) tick();
    check("rescan_q_e8", 32'(q), 32'hF);

    // 6. corner cell: WIDTH=1, DEPTH=4, STABLE_CYCLES=1
    se = 1'b0;
    check("c_stable_idle", 32'(stable2), 32'h1);
    d2 = 1'b1;
    tick(); tick(); tick();
    check("c_q_e3", 32'(q2), 32'h0);
    tick();
    check("c_q_e4", 32'(q2), 32'h1);
    check("c_stable_e4", 32'(stable2), 32'h0);
    tick();
    check("c_stable_e5", 32'(stable2), 32'h1);
    se2 = 1'b1; si2 = 1'b0;
    for (int i = 0; i < 4; i++) tick();
    check("c_flush_so", 32'(so2), 32'h0);
    si2 = 1'b1;
    tick();
    si2 = 1'b0;
    tick(); tick();
    check("c_chain_e3", 32'(so2), 32'h0);
    tick();
    check("c_chain_e4", 32'(so2), 32'h1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/gf180mcu_fd_sc_mcu7t5v0__syncq_mbit.md
Name: gf180mcu_fd_sc_mcu7t5v0__syncq_mbit

Overview:
- Parametrised multi-bit, multi-stage synchroniser cell for the 7-track 5V library.
- It is a bank of WIDTH data bits, each passed through DEPTH flop stages.
- It has a shared hold enable and a full-length scan chain.
- A registered STABLE flag reports that the synchronised output has not changed for STABLE_CYCLES clocks.
- It is placed at clock-domain crossings of MCU designs in place of discrete flop chains, and is DFT-ready.

Parameters:
- WIDTH, 4, number of data bits; legal range 1..32.
- DEPTH, 2, synchroniser stages per bit; legal range 2..4.
- STABLE_CYCLES, 3, unchanged clocks required before STABLE asserts; legal range 1..255.

Ports:
- CLK  input  1  clock, rising-edge active.
- RST  input  1  reset, asynchronous, active-high; clears all state immediately.
- D  input  WIDTH  asynchronous data in.
- E  input  1  functional enable; 0 = hold all stages.
- SE  input  1  scan enable; 1 = shift mode, E ignored.
- SI  input  1  scan in.
- Q  output  WIDTH  synchronised data, equal to the last stage.
- SO  output  1  scan out, driven directly by the last chain flop.
- STABLE  output  1  Q unchanged for at least STABLE_CYCLES functional clocks.
- VDD, VSS  inout  1  present only under USE_POWER_PINS.

Behaviour:
- State:
  - stage[0..DEPTH-1][WIDTH-1:0].
  - cnt, width clog2(STABLE_CYCLES+1).
- Reset (RST=1, independent of CLK):
  - All stage bits = 0 and cnt = 0.
  - Hence Q = 0, SO = 0, STABLE = 0.
  - The first rising edge after deassertion behaves normally (no extra dead cycle).
  - Reset mid-shift or mid-transfer discards all in-flight data.
- Functional mode (SE=0):
  - E=1: stage[0] <= D; stage[k] <= stage[k-1] for k = 1..DEPTH-1.
  - E=0: all stages hold.
  - Q = stage[DEPTH-1]; latency is DEPTH enabled edges from D to Q.
- Scan mode (SE=1), one shift per edge; E is don't-care.
  - Chain order: SI -> stage[0][0] -> stage[0][1] -> ... -> stage[0][WIDTH-1] -> stage[1][0] -> ... -> stage[DEPTH-1][WIDTH-1] -> SO.
  - Chain length = WIDTH*DEPTH.
  - In functional mode SO still equals stage[DEPTH-1][WIDTH-1].
- STABLE counter, evaluated at each rising edge:
  - SE=1: cnt <= 0.
  - SE=0 and the next stage[DEPTH-1] differs from the current one: cnt <= 0.
  - Otherwise: cnt <= min(cnt+1, STABLE_CYCLES), saturating with no wrap.
  - STABLE = (cnt == STABLE_CYCLES), decoded from the register only; no combinational path from D, E or SE.
  - Hold cycles (E=0) count as unchanged cycles.
- Simultaneous events:
  - SE and E both 1: scan wins.
  - RST overrides everything.
- Timing model: outside FUNCTIONAL, a specify block gives:
  - CLK->Q, CLK->SO, CLK->STABLE, RST->Q/SO/STABLE paths;
  - setup/hold on D, E, SE, SI;
  - recovery/removal on RST.
- No X-pessimism beyond standard flop semantics.

Decomposition:
- Shared package gf180mcu_fd_sc_mcu7t5v0__mbit_pkg holds:
  - the parameter legal-range limits;
  - a chain-position function (stage, bit) -> index;
  - the counter-width function.
- One sub-module: gf180mcu_fd_sc_mcu7t5v0__syncq_mbit_func, the untimed functional model (stages, chain, counter).
- The top level instantiates it and adds the power-pin pass-through and the specify block.

Test Plan (WIDTH=4, DEPTH=2, STABLE_CYCLES=3 unless noted):
1. Reset and idle: RST=1 with no clock -> Q=0, SO=0, STABLE=0. Release RST with D=0, E=1, SE=0 -> STABLE=1 after the 3rd edge and stays 1.
2. Latency and STABLE drop:
   - Drive D=4'hA before edge 1, E=1 -> Q=4'hA after edge 2.
   - STABLE=0 after edge 2; STABLE=1 again after edge 5.
3. Hold: E=0 while D toggles 4'h5/4'h3 for 6 edges -> Q holds 4'hA, STABLE remains 1.
4. Scan:
   - SE=1, shift SI = 1,0,1,1,0,0,1,0 (first bit first) over 8 edges -> Q=4'hB, SO=1, STABLE=0.
   - 8 further edges with SI=0 -> SO emits 1,0,1,1,0,0,1,0 in order.
5. Async reset mid-scan: assert RST between edges 4 and 5 of a shift -> Q, SO, STABLE go to 0 immediately without a clock. Next shift starts from an all-zero chain.
6. Corner parameters WIDTH=1, DEPTH=4, STABLE_CYCLES=1:
   - D 0->1 -> Q=1 after exactly 4 enabled edges.
   - STABLE=0 after the changing edge, STABLE=1 one edge later.
   - Scan chain length is 4.
